qk_score_engine: RTL and testbench

Compute stage that answers the attention controller's QK step. It takes the level start held by the controller, computes the scaled score matrix S = (Q·Kᵀ) >>> SHIFT, and writes S into the score buffer. It returns a single-cycle done pulse, then waits for start to drop before it can be started again. It reads Q and K from buffers with 1-cycle read latency and writes scores through a single write port.

---
 rtl/qk_score_engine_if.sv | 48 ++++
 rtl/qk_score_engine.sv | 176 +++++++++++++++++
 tb/tb_qk_score_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qk_score_engine_if.sv
// ---------------------------------------------------------------------------
// qk_score_engine_if
// Bundles the controller handshake, the Q/K buffer read ports, the score
// buffer write port and the state debug output of the QK score engine.
//   start       : level request from the attention controller
//   done        : one-cycle completion pulse
//   busy        : engine is computing (RUN or WRITE)
//   q_addr      : Q buffer read address (row-major i*D_MODEL+k)
//   k_addr      : K buffer read address (row-major j*D_MODEL+k)
//   q_data      : signed Q element, valid the cycle after q_addr
//   k_data      : signed K element, valid the cycle after k_addr
//   s_we        : score write enable
//   s_addr      : score write address (i*SEQ_LEN+j)
//   s_wdata     : scaled, saturated score
//   debug_state : current FSM state encoding
// Modports: slave = engine side, master = controller/buffer side.
// ---------------------------------------------------------------------------
interface qk_score_engine_if #(
   parameter int SEQ_LEN = 4,
   parameter int D_MODEL = 4,
   parameter int DW      = 8,
   parameter int OUT_W   = 16
);
   localparam int QA_W = (SEQ_LEN * D_MODEL > 1) ? $clog2(SEQ_LEN * D_MODEL) : 1;
   localparam int SA_W = (SEQ_LEN * SEQ_LEN > 1) ? $clog2(SEQ_LEN * SEQ_LEN) : 1;

   logic                    start;
   logic                    done;
   logic                    busy;
   logic [QA_W-1:0]         q_addr;
   logic [QA_W-1:0]         k_addr;
   logic signed [DW-1:0]    q_data;
   logic signed [DW-1:0]    k_data;
   logic                    s_we;
   logic [SA_W-1:0]         s_addr;
   logic signed [OUT_W-1:0] s_wdata;
   logic [2:0]              debug_state;

   modport master (
      output start, q_data, k_data,
      input  done, busy, q_addr, k_addr, s_we, s_addr, s_wdata, debug_state
   );

   modport slave (
      input  start, q_data, k_data,
      output done, busy, q_addr, k_addr, s_we, s_addr, s_wdata, debug_state
   );
endinterface

// File: rtl/qk_score_engine.sv
// ---------------------------------------------------------------------------
// qk_score_engine
// Computes S = (Q * K^T) >>> SHIFT for a SEQ_LEN x D_MODEL pair of matrices
// held in external buffers with one-cycle read latency, and writes each
// saturated score to the score buffer in address order 0..SEQ_LEN^2-1.
// Each score element takes D_MODEL RUN cycles (one read per k) followed by
// one WRITE cycle in which the last product is folded in combinationally.
// After the last write a one-cycle done pulse is raised; a start that is
// still held afterwards parks the engine in HOLD until it drops.
//   clk : clock
//   rst : asynchronous, active-high reset
//   bus : qk_score_engine_if.slave (handshake, Q/K reads, score writes)
// ---------------------------------------------------------------------------
module qk_score_engine #(
   parameter int SEQ_LEN = 4,
   parameter int D_MODEL = 4,
   parameter int DW      = 8,
   parameter int OUT_W   = 16,
   parameter int SHIFT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   qk_score_engine_if.slave  bus
);

   localparam int QA_W  = (SEQ_LEN * D_MODEL > 1) ? $clog2(SEQ_LEN * D_MODEL) : 1;
   localparam int SA_W  = (SEQ_LEN * SEQ_LEN > 1) ? $clog2(SEQ_LEN * SEQ_LEN) : 1;
   localparam int I_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int K_W   = (D_MODEL > 1) ? $clog2(D_MODEL) : 1;
   localparam int PW    = 2 * DW;
   // Sum of D_MODEL full-range products needs $clog2(D_MODEL) guard bits.
   localparam int ACC_W = PW + $clog2(D_MODEL);
   // Saturation compare width wide enough for both the accumulator and the
   // output range, plus a sign bit of headroom.
   localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic signed [CW-1:0] SAT_MAX = (CW'(1) <<< (OUT_W - 1)) - CW'(1);
   localparam logic signed [CW-1:0] SAT_MIN = -(CW'(1) <<< (OUT_W - 1));

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic [2:0]              state;
   logic [I_W-1:0]          i_cnt;
   logic [I_W-1:0]          j_cnt;
   logic [K_W-1:0]          k_cnt;
   logic signed [ACC_W-1:0] acc;

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] final_sum;
   logic                    last_k;
   logic                    last_j;
   logic                    last_i;
   logic [I_W-1:0]          i_nxt;
   logic [I_W-1:0]          j_nxt;
   logic [SA_W-1:0]         elem_addr;

   // Arithmetic (sign-preserving) scaling of the completed dot product.
   function automatic logic signed [ACC_W-1:0] scale_score(input logic signed [ACC_W-1:0] v);
      scale_score = v >>> SHIFT;
   endfunction

   // Clamp to the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] sat_score(input logic signed [ACC_W-1:0] v);
      logic signed [CW-1:0] w;
      w = CW'(v);
      if (w > SAT_MAX) begin
         sat_score = SAT_MAX[OUT_W-1:0];
      end else if (w < SAT_MIN) begin
         sat_score = SAT_MIN[OUT_W-1:0];
      end else begin
         sat_score = w[OUT_W-1:0];
      end
   endfunction

   function automatic logic [QA_W-1:0] row_addr(input logic [I_W-1:0] row, input int col);
      row_addr = QA_W'(int'(row) * D_MODEL + col);
   endfunction

   // ---- Read-data stage: product of the elements requested last cycle ----
   assign prod      = PW'(bus.q_data) * PW'(bus.k_data);
   assign prod_ext  = ACC_W'(prod);
   assign final_sum = acc + prod_ext;

   assign last_k    = (k_cnt == K_W'(D_MODEL - 1));
   assign last_j    = (j_cnt == I_W'(SEQ_LEN - 1));
   assign last_i    = (i_cnt == I_W'(SEQ_LEN - 1));
   assign elem_addr = SA_W'(int'(i_cnt) * SEQ_LEN + int'(j_cnt));

   // Element advance: j walks the columns, i steps when j wraps.
   always_comb begin
      i_nxt = i_cnt;
      j_nxt = j_cnt + 1'b1;
      if (last_j) begin
         j_nxt = '0;
         i_nxt = last_i ? '0 : i_cnt + 1'b1;
      end
   end

   // ---- Control / accumulate stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         i_cnt      <= '0;
         j_cnt      <= '0;
         k_cnt      <= '0;
         acc        <= '0;
         bus.q_addr <= '0;
         bus.k_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               i_cnt      <= '0;
               j_cnt      <= '0;
               k_cnt      <= '0;
               acc        <= '0;
               bus.q_addr <= '0;
               bus.k_addr <= '0;
               if (bus.start) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // The first RUN cycle of an element has no read data yet.
               if (k_cnt != '0) begin
                  acc <= final_sum;
               end
               if (last_k) begin
                  state <= S_WRITE;
               end else begin
                  k_cnt      <= k_cnt + 1'b1;
                  bus.q_addr <= row_addr(i_cnt, int'(k_cnt) + 1);
                  bus.k_addr <= row_addr(j_cnt, int'(k_cnt) + 1);
               end
            end
            S_WRITE: begin
               acc        <= '0;
               k_cnt      <= '0;
               i_cnt      <= i_nxt;
               j_cnt      <= j_nxt;
               bus.q_addr <= row_addr(i_nxt, 0);
               bus.k_addr <= row_addr(j_nxt, 0);
               if (last_i && last_j) begin
                  state <= S_DONE;
               end else begin
                  state <= S_RUN;
               end
            end
            S_DONE: begin
               state <= bus.start ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
               if (!bus.start) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ---- Write stage: final sum is scaled and saturated without a register ----
   assign bus.s_we        = (state == S_WRITE);
   assign bus.s_addr      = (state == S_WRITE) ? elem_addr : '0;
   assign bus.s_wdata     = (state == S_WRITE) ? sat_score(scale_score(final_sum)) : '0;
   assign bus.busy        = (state == S_RUN) || (state == S_WRITE);
   assign bus.done        = (state == S_DONE);
   assign bus.debug_state = state;

endmodule

// File: tb/tb_qk_score_engine.sv
// ---------------------------------------------------------------------------
// tb_qk_score_engine
// Randomised and directed stimulus for qk_score_engine. Each run pushes the
// expected score writes (address, value) into a queue computed from the
// matrix definition; a monitor pops one entry per observed write.
// ---------------------------------------------------------------------------
module tb_qk_score_engine;
   localparam int SEQ_LEN = 4;
   localparam int D_MODEL = 4;
   localparam int DW      = 8;
   localparam int OUT_W   = 16;
   localparam int SHIFT   = 1;
   localparam int NQ      = SEQ_LEN * D_MODEL;
   localparam int NS      = SEQ_LEN * SEQ_LEN;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   qk_score_engine_if #(.SEQ_LEN(SEQ_LEN), .D_MODEL(D_MODEL), .DW(DW), .OUT_W(OUT_W)) bus ();

   qk_score_engine #(
      .SEQ_LEN(SEQ_LEN), .D_MODEL(D_MODEL), .DW(DW), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic signed [DW-1:0] qm [NQ];
   logic signed [DW-1:0] km [NQ];

   // Q/K buffers with one-cycle read latency.
   always @(posedge clk) begin
      bus.q_data <= qm[bus.q_addr];
      bus.k_data <= km[bus.k_addr];
   end

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         busy_cnt, done_cnt, done_cyc, run_cyc;
   logic [2:0] prev_state = 3'd0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: dot product, floor-divide by 2^SHIFT, clamp to OUT_W range.
   function automatic int ref_score(input int i, input int j);
      int  s;
      real r;
      s = 0;
      for (int k = 0; k < D_MODEL; k++) begin
         s += int'(qm[i * D_MODEL + k]) * int'(km[j * D_MODEL + k]);
      end
      r = $floor(real'(s) / real'(1 << SHIFT));
      s = int'(r);
      if (s > (1 << (OUT_W - 1)) - 1) s = (1 << (OUT_W - 1)) - 1;
      if (s < -(1 << (OUT_W - 1)))    s = -(1 << (OUT_W - 1));
      return s;
   endfunction

   task automatic push_expected();
      for (int a = 0; a < NS; a++) begin
         sb.push_back('{a, ref_score(a / SEQ_LEN, a % SEQ_LEN)});
      end
   endtask

   // Monitor: samples 1 time unit after every rising edge.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      #1;
      if (bus.s_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e = sb.pop_front();
            check("s_addr", int'(bus.s_addr), e.addr);
            check("s_wdata", int'(bus.s_wdata), e.data);
         end
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.debug_state == 3'd1 && prev_state == 3'd0) run_cyc = cyc;
      prev_state = bus.debug_state;
   end

   // mode 0: start held until done; 1: one-cycle start pulse;
   // 2: start held five cycles past done.
   task automatic do_run(input int mode);
      int t;
      push_expected();
      busy_cnt = 0;
      done_cnt = 0;
      done_cyc = -1;
      run_cyc  = -1;
      @(negedge clk);
      bus.start = 1'b1;
      if (mode == 1) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      t = 0;
      while (done_cnt == 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == 0) check("done_timeout", 0, 1);
      if (mode == 2) begin
         for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #2;
            check("hold_state", int'(bus.debug_state), 4);
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      check("idle_after_run", int'(bus.debug_state), 0);
      check("done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cnt, NS * (D_MODEL + 1));
      // done rises 80 edges after the start-sampling edge, so the
      // controller captures it on the 81st.
      check("done_latency", done_cyc - run_cyc, NS * (D_MODEL + 1));
      check("writes_pending", sb.size(), 0);
   endtask

   task automatic fill_random();
      for (int a = 0; a < NQ; a++) begin
         qm[a] = DW'($urandom);
         km[a] = DW'($urandom);
      end
   endtask

   task automatic reset_mid_run();
      int t;
      push_expected();
      @(negedge clk);
      bus.start = 1'b1;
      t = 0;
      while (!(bus.s_we === 1'b1 && bus.s_addr == 4'd5) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("addr5_timeout", 0, 1);
      rst = 1'b1;
      #1;
      check("rst_s_we", int'(bus.s_we), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_s_addr", int'(bus.s_addr), 0);
      check("rst_s_wdata", int'(bus.s_wdata), 0);
      check("rst_q_addr", int'(bus.q_addr), 0);
      check("rst_k_addr", int'(bus.k_addr), 0);
      check("rst_state", int'(bus.debug_state), 0);
      sb.delete();
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      for (int a = 0; a < NQ; a++) begin
         qm[a] = '0;
         km[a] = '0;
      end
      #12;
      check("reset_state", int'(bus.debug_state), 0);
      check("reset_s_we", int'(bus.s_we), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_q_addr", int'(bus.q_addr), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // All ones: every score is 4 >>> 1 = 2.
      for (int a = 0; a < NQ; a++) begin
         qm[a] = 8'sd1;
         km[a] = 8'sd1;
      end
      do_run(0);

      // Row-indexed values: score(i,j) = 2(i+1)(j+1); held start, then rerun.
      for (int r = 0; r < SEQ_LEN; r++) begin
         for (int k = 0; k < D_MODEL; k++) begin
            qm[r * D_MODEL + k] = DW'(r + 1);
            km[r * D_MODEL + k] = DW'(r + 1);
         end
      end
      do_run(2);
      do_run(0);

      // Saturation corners on row 0 with a single-cycle start pulse.
      fill_random();
      for (int k = 0; k < D_MODEL; k++) begin
         qm[k]           = 8'sh80;
         km[k]           = 8'sh80;
         km[D_MODEL + k] = 8'sh7f;
      end
      do_run(1);

      // Random matrices with random start styles.
      for (int n = 0; n < 3; n++) begin
         fill_random();
         do_run(int'($urandom_range(0, 2)));
      end

      // Extreme values only.
      for (int a = 0; a < NQ; a++) begin
         qm[a] = ($urandom % 2) ? 8'sh80 : 8'sh7f;
         km[a] = ($urandom % 2) ? 8'sh80 : 8'sh7f;
      end
      do_run(0);

      // Reset in the middle of a run, then a clean restart from address 0.
      fill_random();
      reset_mid_run();
      do_run(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
